dot_product_matvec_sched: RTL and testbench
===========================================

// Module: dot_product_matvec_sched
// PURPOSE
//   Sequencer that computes a matrix-vector product y = M*v on one shared vec_dot_product_param instance.
//   Latches vector v once, streams up to ROWS_MAX matrix rows through the dot-product unit one per cycle,
//   and returns each row result over a valid/ready stream tagged with its row index.
//   Sits between the test-vector/host feed and the dot-product datapath; owns all sequencing and backpressure.
// PARAMETERS
//   N             8   elements per vector/row; passed to vec_dot_product_param
//   SCALAR_WIDTH  8   unsigned width of each element
//   ROWS_MAX      16  max rows per job
//   DOT_WIDTH     $clog2(N*(2**SCALAR_WIDTH-1)**2+1)  result width; derived, do not override
//   IDX_W         $clog2(ROWS_MAX+1)                  row count/index width; derived
// PORTS
//   clk        in   1                single clock, rising edge
//   rst_n      in   1                asynchronous active-low reset
//   start      in   1                job start pulse; sampled only in IDLE
//   num_rows   in   IDX_W            row count for the job, sampled with start; values > ROWS_MAX clamp to ROWS_MAX
//   vec_in     in   N*SCALAR_WIDTH   vector v; element i at [i*SCALAR_WIDTH +: SCALAR_WIDTH]
//   vec_valid  in   1                vec_in valid
//   vec_ready  out  1                high only in LOAD_VEC
//   row_in     in   N*SCALAR_WIDTH   matrix row, same packing as vec_in
//   row_valid  in   1                row_in valid
//   row_ready  out  1                row accept (see BEHAVIOUR)
//   res_out    out  DOT_WIDTH        registered dot(row, v)
//   res_idx    out  IDX_W            row index of res_out, 0-based
//   res_last   out  1                res_out belongs to the final row of the job
//   res_valid  out  1                result valid
//   res_ready  in   1                downstream accept
//   busy       out  1                state != IDLE
//   done       out  1                one-cycle pulse at job completion
// BEHAVIOUR
//   Reset: state=IDLE; vec_ready, row_ready, res_valid, res_last, busy, done = 0; res_out, res_idx = 0; vector register = 0.
//   Reset asserted mid-job aborts it immediately: any held result is dropped and no done is pulsed.
//   FSM: IDLE -> LOAD_VEC on start with num_rows != 0.
//        IDLE, start with num_rows == 0: stay IDLE; done pulses the next cycle; no handshakes occur.
//        LOAD_VEC -> STREAM on vec_valid && vec_ready; vec_in is captured into the vector register.
//        STREAM -> IDLE on the cycle the result with res_last handshakes (res_valid && res_ready);
//        done pulses the cycle after that handshake.
//   start while busy is ignored; num_rows is latched only at an accepted start.
//   row_ready = (state==STREAM) && (issued < rows) && (!res_valid || res_ready).
//   Single-entry output register: a row accepted in cycle k makes res_valid=1 at cycle k+1, carrying
//     dot(row_in, v), idx=issued, and last=(issued==rows-1).
//   Back-to-back rows: full throughput of 1 row/cycle while res_ready=1.
//   Backpressure: while res_valid && !res_ready, res_out/res_idx/res_last hold stable and row_ready=0.
//   res_valid drops after a handshake unless a new row is accepted in the same cycle.
//   Arithmetic: unsigned throughout; DOT_WIDTH holds N*(2^SW-1)^2 exactly; no truncation or saturation.
//   issued counter: 0..rows, resets to 0 on entering LOAD_VEC; never wraps.
//   Row or vector data presented outside its ready window is ignored (no capture).
// TESTING
//   T1 reset: rst_n=0 with random inputs -> all outputs 0, busy=0; release -> stay IDLE until start.
//   T2 basic: num_rows=3, v=all 1, rows {all 1, all 2, all 255} -> results 8, 16, 2040 with idx 0,1,2;
//      last only on idx 2; done 1 cycle after the 3rd handshake.
//   T3 max/throughput: N=8, num_rows=16, all 255 vs all 255, res_ready=1, row_valid=1 ->
//      16 results of 520200, one per cycle; idx 0..15.
//   T4 backpressure: res_ready=0 for 5 cycles after the 1st result -> res_out/res_idx stable,
//      row_ready=0, no row lost; results in order.
//   T5 edges: start with num_rows=0 -> done next cycle, busy stays 0;
//      start while busy -> ignored; num_rows=20 -> exactly 16 results.
//   T6 mid-job reset: assert rst_n=0 after 2 of 4 results -> outputs 0 asynchronously, no done;
//      a following job runs clean with idx starting at 0.

Source files
------------

// File: rtl/dot_product_matvec_sched.sv
// Matrix-vector sequencer: latches v once, streams rows through a shared dot-product unit
// and returns each row result on a single-entry valid/ready output register.

module vec_dot_product_param #(
  parameter int N            = 8,
  parameter int SCALAR_WIDTH = 8,
  parameter int DOT_WIDTH    = $clog2(N*(2**SCALAR_WIDTH-1)**2+1)
) (
  input  logic [N*SCALAR_WIDTH-1:0] a,
  input  logic [N*SCALAR_WIDTH-1:0] b,
  output logic [DOT_WIDTH-1:0]      dot
);

  // Unsigned sum of element products, each operand widened so nothing truncates
  always_comb begin
    dot = '0;
    for (int i = 0; i < N; i++) begin
      dot = dot + (DOT_WIDTH'(a[i*SCALAR_WIDTH +: SCALAR_WIDTH]) *
                   DOT_WIDTH'(b[i*SCALAR_WIDTH +: SCALAR_WIDTH]));
    end
  end

endmodule

module dot_product_matvec_sched #(
  parameter int N            = 8,
  parameter int SCALAR_WIDTH = 8,
  parameter int ROWS_MAX     = 16,
  parameter int DOT_WIDTH    = $clog2(N*(2**SCALAR_WIDTH-1)**2+1),
  parameter int IDX_W        = $clog2(ROWS_MAX+1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [IDX_W-1:0]          num_rows,
  input  logic [N*SCALAR_WIDTH-1:0] vec_in,
  input  logic                      vec_valid,
  output logic                      vec_ready,
  input  logic [N*SCALAR_WIDTH-1:0] row_in,
  input  logic                      row_valid,
  output logic                      row_ready,
  output logic [DOT_WIDTH-1:0]      res_out,
  output logic [IDX_W-1:0]          res_idx,
  output logic                      res_last,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LOAD_VEC = 2'd1,
    ST_STREAM   = 2'd2
  } state_t;

  state_t                    state_r, state_next_s;
  logic [N*SCALAR_WIDTH-1:0] vec_r;
  logic [IDX_W-1:0]          rows_r, issued_r, rows_clamped_s;
  logic [DOT_WIDTH-1:0]      res_out_r, dot_s;
  logic [IDX_W-1:0]          res_idx_r;
  logic                      res_last_r, res_valid_r;
  logic                      vec_ready_r, busy_r, done_r;
  logic                      row_ready_s, row_acc_s, vec_acc_s, res_hs_s;
  logic                      start_acc_s, zero_job_s;

  vec_dot_product_param #(
    .N            (N),
    .SCALAR_WIDTH (SCALAR_WIDTH),
    .DOT_WIDTH    (DOT_WIDTH)
  ) u_dot (
    .a   (row_in),
    .b   (vec_r),
    .dot (dot_s)
  );

  // Handshake qualifiers and job-size clamp
  always_comb begin
    start_acc_s = (state_r == ST_IDLE) && start && (num_rows != '0);
    zero_job_s  = (state_r == ST_IDLE) && start && (num_rows == '0);
    vec_acc_s   = (state_r == ST_LOAD_VEC) && vec_ready_r && vec_valid;
    res_hs_s    = res_valid_r && res_ready;
    row_ready_s = (state_r == ST_STREAM) && (issued_r < rows_r) && (!res_valid_r || res_ready);
    row_acc_s   = row_ready_s && row_valid;
    if (num_rows > IDX_W'(ROWS_MAX)) begin
      rows_clamped_s = IDX_W'(ROWS_MAX);
    end else begin
      rows_clamped_s = num_rows;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_acc_s) state_next_s = ST_LOAD_VEC;
        else             state_next_s = ST_IDLE;
      end
      ST_LOAD_VEC: begin
        if (vec_acc_s) state_next_s = ST_STREAM;
        else           state_next_s = ST_LOAD_VEC;
      end
      ST_STREAM: begin
        if (res_hs_s && res_last_r) state_next_s = ST_IDLE;
        else                        state_next_s = ST_STREAM;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register and registered status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      vec_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      vec_ready_r <= (state_next_s == ST_LOAD_VEC);
      busy_r      <= (state_next_s != ST_IDLE);
      done_r      <= zero_job_s || ((state_r == ST_STREAM) && res_hs_s && res_last_r);
    end
  end

  // Job bookkeeping: vector capture, row budget and issue counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_r    <= '0;
      rows_r   <= '0;
      issued_r <= '0;
    end else begin
      if (start_acc_s) begin
        rows_r   <= rows_clamped_s;
        issued_r <= '0;
      end else if (row_acc_s) begin
        issued_r <= issued_r + IDX_W'(1);
      end
      if (vec_acc_s) begin
        vec_r <= vec_in;
      end
    end
  end

  // Single-entry result register; a new row may refill it in the same cycle it drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_out_r   <= '0;
      res_idx_r   <= '0;
      res_last_r  <= 1'b0;
      res_valid_r <= 1'b0;
    end else if (row_acc_s) begin
      res_out_r   <= dot_s;
      res_idx_r   <= issued_r;
      res_last_r  <= (issued_r == rows_r - IDX_W'(1));
      res_valid_r <= 1'b1;
    end else if (res_hs_s) begin
      res_last_r  <= 1'b0;
      res_valid_r <= 1'b0;
    end
  end

  assign vec_ready = vec_ready_r;
  assign row_ready = row_ready_s;
  assign res_out   = res_out_r;
  assign res_idx   = res_idx_r;
  assign res_last  = res_last_r;
  assign res_valid = res_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_dot_product_matvec_sched.sv
// Self-checking bench for dot_product_matvec_sched: table-driven jobs, hand-built corner
// sequences and randomized jobs checked against an arithmetic reference model.

module tb_dot_product_matvec_sched;

  localparam int N     = 8;
  localparam int SW    = 8;
  localparam int RMAX  = 16;
  localparam int DW    = $clog2(N*(2**SW-1)**2+1);
  localparam int IW    = $clog2(RMAX+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [IW-1:0]     num_rows = '0;
  logic [N*SW-1:0]   vec_in = '0;
  logic              vec_valid = 1'b0;
  logic              vec_ready;
  logic [N*SW-1:0]   row_in = '0;
  logic              row_valid = 1'b0;
  logic              row_ready;
  logic [DW-1:0]     res_out;
  logic [IW-1:0]     res_idx;
  logic              res_last;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  logic [N*SW-1:0] row_data [0:31];
  longint          exp_val  [0:31];

  typedef struct {
    int     nrows;
    int     velem;
    int     relem;
    longint expv;
  } job_vec_t;

  job_vec_t tbl [0:5];

  dot_product_matvec_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .vec_in    (vec_in),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .row_in    (row_in),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .res_out   (res_out),
    .res_idx   (res_idx),
    .res_last  (res_last),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic logic [N*SW-1:0] splat(input int e);
    logic [N*SW-1:0] r;
    for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'(e);
    return r;
  endfunction

  function automatic longint ref_dot(input logic [N*SW-1:0] r, input logic [N*SW-1:0] v);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(r[i*SW +: SW]) * longint'(v[i*SW +: SW]);
    return s;
  endfunction

  task automatic chk_all_zero(input string name);
    chk(name, 64'({vec_ready, row_ready, res_valid, res_last, busy, done, res_out, res_idx}), 64'd0);
  endtask

  // mode: 0 res_ready always 1, 1 random, 2 stall 5 cycles after the first result
  task automatic run_job(input int nreq, input logic [N*SW-1:0] v, input int mode,
                         input bit rv_rand, input bit poke_start, input int abort_after,
                         input bit chk_tp);
    int exp_n = (nreq > RMAX) ? RMAX : nreq;
    int sent = 0, got = 0, stall_left = 0, first_cyc = 0, last_cyc = 0;
    bit vec_done = 1'b0, finished = 1'b0, stall_seen = 1'b0;
    logic [DW-1:0] h_out;
    logic [IW-1:0] h_idx;
    logic          h_last;
    @(negedge clk);
    start = 1'b1;
    num_rows = IW'(nreq);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", 64'(busy), 64'(exp_n != 0));
    chk("done_after_start", 64'(done), 64'(exp_n == 0));
    if (exp_n == 0) begin
      @(negedge clk);
      #1;
      chk("zero_job_done_clear", 64'(done), 64'd0);
      chk("zero_job_idle", 64'(busy), 64'd0);
      return;
    end
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      start    = poke_start && (cyc == 3);
      num_rows = poke_start ? IW'(2) : IW'(nreq);
      vec_valid = !vec_done;
      vec_in    = vec_done ? {$urandom, $urandom} : v;
      if (sent < exp_n) begin
        row_valid = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        row_in    = row_data[sent];
      end else begin
        row_valid = 1'($urandom_range(0, 1));
        row_in    = {$urandom, $urandom};
      end
      case (mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'($urandom_range(0, 1));
        default: res_ready = (stall_left == 0);
      endcase
      #1;
      if (stall_seen) begin
        chk("bp_valid_hold", 64'(res_valid), 64'd1);
        chk("bp_out_hold", 64'(res_out), 64'(h_out));
        chk("bp_idx_hold", 64'(res_idx), 64'(h_idx));
        chk("bp_last_hold", 64'(res_last), 64'(h_last));
      end
      if (vec_valid && vec_ready) vec_done = 1'b1;
      if (row_valid && row_ready) begin
        if (sent < exp_n) sent++;
        else chk("extra_row_accept", 64'd1, 64'd0);
      end
      if (res_valid && !res_ready) begin
        chk("bp_row_ready", 64'(row_ready), 64'd0);
        h_out = res_out; h_idx = res_idx; h_last = res_last;
        stall_seen = 1'b1;
      end else begin
        stall_seen = 1'b0;
      end
      if (mode == 2 && !res_ready && stall_left > 0) stall_left--;
      if (res_valid && res_ready) begin
        chk("res_out", 64'(res_out), 64'(exp_val[got]));
        chk("res_idx", 64'(res_idx), 64'(got));
        chk("res_last", 64'(res_last), 64'(got == exp_n - 1));
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
        if (mode == 2 && got == 1) stall_left = 5;
        if (got == exp_n || got == abort_after) finished = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    row_valid = 1'b0;
    vec_valid = 1'b0;
    start     = 1'b0;
    if (!finished) chk("timeout_results", 64'(got), 64'(exp_n));
    if (abort_after != 0) return;
    res_ready = 1'b0;
    #1;
    chk("done_pulse", 64'(done), 64'd1);
    chk("idle_after_job", 64'(busy), 64'd0);
    chk("no_extra_result", 64'(res_valid), 64'd0);
    if (chk_tp) chk("throughput", 64'(last_cyc - first_cyc), 64'(exp_n - 1));
    @(negedge clk);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
  endtask

  initial begin
    logic [N*SW-1:0] v;
    int nreq;

    tbl[0] = '{3, 1, 1, 64'd8};
    tbl[1] = '{4, 1, 2, 64'd16};
    tbl[2] = '{16, 255, 255, 64'd520200};
    tbl[3] = '{20, 255, 255, 64'd520200};
    tbl[4] = '{1, 0, 255, 64'd0};
    tbl[5] = '{5, 3, 7, 64'd168};

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      start = 1'($urandom_range(0, 1)); num_rows = IW'($urandom_range(1, 20));
      vec_valid = 1'($urandom_range(0, 1)); row_valid = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1)); vec_in = {$urandom, $urandom};
      row_in = {$urandom, $urandom};
      @(negedge clk);
      #1;
      chk_all_zero("reset_outputs");
    end
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vec_valid = 1'($urandom_range(0, 1)); row_valid = 1'($urandom_range(0, 1));
      res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      chk("idle_without_start", 64'({busy, res_valid, vec_ready, done}), 64'd0);
    end
    vec_valid = 1'b0; row_valid = 1'b0;

    // Basic three-row job with distinct rows
    row_data[0] = splat(1); row_data[1] = splat(2); row_data[2] = splat(255);
    exp_val[0] = 8; exp_val[1] = 16; exp_val[2] = 2040;
    run_job(3, splat(1), 0, 1'b0, 1'b0, 0, 1'b0);

    // Table of uniform jobs (includes full-size, clamp and start-while-busy)
    for (int t = 0; t < 6; t++) begin
      for (int r = 0; r < 32; r++) begin
        row_data[r] = splat(tbl[t].relem);
        exp_val[r]  = tbl[t].expv;
      end
      run_job(tbl[t].nrows, splat(tbl[t].velem), 0, 1'b0, (t == 5), 0, (t == 2));
    end

    // Backpressure: 5-cycle stall after the first result, distinct rows
    v = {$urandom, $urandom};
    for (int r = 0; r < 6; r++) begin
      row_data[r] = {$urandom, $urandom};
      exp_val[r]  = ref_dot(row_data[r], v);
    end
    run_job(6, v, 2, 1'b0, 1'b0, 0, 1'b0);

    // Zero-row job
    run_job(0, splat(9), 0, 1'b0, 1'b0, 0, 1'b0);

    // Mid-job reset after 2 of 4 results
    v = {$urandom, $urandom};
    for (int r = 0; r < 4; r++) begin
      row_data[r] = {$urandom, $urandom};
      exp_val[r]  = ref_dot(row_data[r], v);
    end
    run_job(4, v, 0, 1'b0, 1'b0, 2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("no_done_after_abort", 64'({done, busy, res_valid}), 64'd0);
    end
    run_job(4, v, 0, 1'b0, 1'b0, 0, 1'b0);

    // Randomized jobs against the reference model
    for (int j = 0; j < 6; j++) begin
      nreq = $urandom_range(1, 20);
      v = {$urandom, $urandom};
      for (int r = 0; r < 32; r++) begin
        row_data[r] = {$urandom, $urandom};
        exp_val[r]  = ref_dot(row_data[r], v);
      end
      run_job(nreq, v, 1, 1'b1, 1'b0, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
